// File: rtl/sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter
//
// Shares the single SDRAM controller request port between the Atari core
// (CPU/ANTIC memory cycles) and the data_io loader (ROM/cartridge/disk image
// upload). One transaction is latched at a time, forwarded downstream, and
// its completion (ack + read data) is routed back to whichever requester
// owned it. A watchdog aborts a transaction that the controller never
// acknowledges so that no requester can hang.
//
// Optional feature macro: ARB_RR_EN
//   undefined : fixed priority, core wins over loader.
//   defined   : round-robin; when both request, the one not served last wins.
//
// Parameters
//   ADDR_W  : byte address width of every port
//   DATA_W  : data width of every port (byte enables are DATA_W/8 bits)
//   TIMEOUT : max ISSUE cycles to wait for sd_ack before aborting (>= 2)
//
// Ports
//   clk, reset_n              : clock, asynchronous active-low reset
//   core_req/we/addr/wdata/be : core request (req held until core_ack)
//   core_rdata, core_ack      : core completion (rdata held after ack)
//   ld_req/we/addr/wdata/be   : loader request
//   ld_rdata, ld_ack          : loader completion
//   sd_req/we/addr/wdata/be   : downstream request to the SDRAM controller
//   sd_rdata, sd_ack          : downstream completion
//   owner                     : 00 none, 01 core, 10 loader
//   busy                      : high whenever the FSM is not IDLE
//   err_clr, timeout_err      : sticky watchdog flag and its clear
// ---------------------------------------------------------------------------
module sdram_req_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [DATA_W/8-1:0]   core_be,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_ack,

    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_wdata,
    input  logic [DATA_W/8-1:0]   ld_be,
    output logic [DATA_W-1:0]     ld_rdata,
    output logic                  ld_ack,

    output logic                  sd_req,
    output logic                  sd_we,
    output logic [ADDR_W-1:0]     sd_addr,
    output logic [DATA_W-1:0]     sd_wdata,
    output logic [DATA_W/8-1:0]   sd_be,
    input  logic [DATA_W-1:0]     sd_rdata,
    input  logic                  sd_ack,

    output logic [1:0]            owner,
    output logic                  busy,
    input  logic                  err_clr,
    output logic                  timeout_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state_reg,       state_next;
    logic                sd_req_reg,      sd_req_next;
    logic                sd_we_reg,       sd_we_next;
    logic [ADDR_W-1:0]   sd_addr_reg,     sd_addr_next;
    logic [DATA_W-1:0]   sd_wdata_reg,    sd_wdata_next;
    logic [BE_W-1:0]     sd_be_reg,       sd_be_next;
    logic [1:0]          owner_reg,       owner_next;
    logic [WD_W-1:0]     wd_reg,          wd_next;
    logic                core_ack_reg,    core_ack_next;
    logic                ld_ack_reg,      ld_ack_next;
    logic [DATA_W-1:0]   core_rdata_reg,  core_rdata_next;
    logic [DATA_W-1:0]   ld_rdata_reg,    ld_rdata_next;
    logic                timeout_err_reg, timeout_err_next;
`ifdef ARB_RR_EN
    // 1 = loader was served last, 0 = core (also the reset value).
    logic                last_ld_reg,     last_ld_next;
`endif

    // Arbitration decision, only meaningful in IDLE.
    logic                pick_ld;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;

    // Watchdog fires at the end of the TIMEOUT-th ISSUE cycle.
    logic                wd_hit;
    logic                err_set;
    logic [DATA_W-1:0]   done_data;

`ifdef ARB_RR_EN
    // When both request, favour whoever was not served last.
    assign pick_ld = ld_req && (!core_req || !last_ld_reg);
`else
    // Core always wins; loader only gets the port when the core is quiet.
    assign pick_ld = ld_req && !core_req;
`endif

    // Per-byte-lane payload select from the winning requester.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            assign sel_wdata[gi*8 +: 8] = pick_ld ? ld_wdata[gi*8 +: 8]
                                                  : core_wdata[gi*8 +: 8];
            assign sel_be[gi]           = pick_ld ? ld_be[gi] : core_be[gi];
        end
    endgenerate

    assign wd_hit = (wd_reg == WD_W'(TIMEOUT - 1));

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        sd_req_next     = sd_req_reg;
        sd_we_next      = sd_we_reg;
        sd_addr_next    = sd_addr_reg;
        sd_wdata_next   = sd_wdata_reg;
        sd_be_next      = sd_be_reg;
        owner_next      = owner_reg;
        wd_next         = wd_reg;
        core_ack_next   = 1'b0;
        ld_ack_next     = 1'b0;
        core_rdata_next = core_rdata_reg;
        ld_rdata_next   = ld_rdata_reg;
        err_set         = 1'b0;
        done_data       = '1;
`ifdef ARB_RR_EN
        last_ld_next    = last_ld_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (core_req || ld_req) begin
                    state_next    = ST_ISSUE;
                    sd_req_next   = 1'b1;
                    sd_we_next    = pick_ld ? ld_we   : core_we;
                    sd_addr_next  = pick_ld ? ld_addr : core_addr;
                    sd_wdata_next = sel_wdata;
                    sd_be_next    = sel_be;
                    owner_next    = pick_ld ? OWN_LD : OWN_CORE;
                    wd_next       = '0;
                end
            end

            ST_ISSUE: begin
                wd_next = wd_reg + WD_W'(1);
                // sd_ack takes precedence over a coincident watchdog expiry.
                if (sd_ack || wd_hit) begin
                    state_next  = ST_RELEASE;
                    sd_req_next = 1'b0;
                    owner_next  = OWN_NONE;
                    done_data   = sd_ack ? sd_rdata : '1;
                    err_set     = !sd_ack;
                    if (owner_reg == OWN_LD) begin
                        ld_ack_next   = 1'b1;
                        ld_rdata_next = done_data;
                    end else begin
                        core_ack_next   = 1'b1;
                        core_rdata_next = done_data;
                    end
`ifdef ARB_RR_EN
                    last_ld_next = (owner_reg == OWN_LD);
`endif
                end
            end

            // One dead cycle so a requester that keeps req high after its
            // ack is not granted a second time from the same ack.
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next  = ST_IDLE;
                sd_req_next = 1'b0;
                owner_next  = OWN_NONE;
            end
        endcase

        // A new timeout beats a simultaneous clear.
        if (err_set) begin
            timeout_err_next = 1'b1;
        end else if (err_clr) begin
            timeout_err_next = 1'b0;
        end else begin
            timeout_err_next = timeout_err_reg;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            sd_req_reg      <= 1'b0;
            sd_we_reg       <= 1'b0;
            sd_addr_reg     <= '0;
            sd_wdata_reg    <= '0;
            sd_be_reg       <= '0;
            owner_reg       <= OWN_NONE;
            wd_reg          <= '0;
            core_ack_reg    <= 1'b0;
            ld_ack_reg      <= 1'b0;
            core_rdata_reg  <= '0;
            ld_rdata_reg    <= '0;
            timeout_err_reg <= 1'b0;
`ifdef ARB_RR_EN
            last_ld_reg     <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            sd_req_reg      <= sd_req_next;
            sd_we_reg       <= sd_we_next;
            sd_addr_reg     <= sd_addr_next;
            sd_wdata_reg    <= sd_wdata_next;
            sd_be_reg       <= sd_be_next;
            owner_reg       <= owner_next;
            wd_reg          <= wd_next;
            core_ack_reg    <= core_ack_next;
            ld_ack_reg      <= ld_ack_next;
            core_rdata_reg  <= core_rdata_next;
            ld_rdata_reg    <= ld_rdata_next;
            timeout_err_reg <= timeout_err_next;
`ifdef ARB_RR_EN
            last_ld_reg     <= last_ld_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from registers, so reset clears them at once)
    // -----------------------------------------------------------------------
    assign sd_req      = sd_req_reg;
    assign sd_we       = sd_we_reg;
    assign sd_addr     = sd_addr_reg;
    assign sd_wdata    = sd_wdata_reg;
    assign sd_be       = sd_be_reg;
    assign owner       = owner_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign core_ack    = core_ack_reg;
    assign ld_ack      = ld_ack_reg;
    assign core_rdata  = core_rdata_reg;
    assign ld_rdata    = ld_rdata_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for sdram_req_arbiter (default parameters).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_sdram_req_arbiter;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              core_req, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [1:0]        core_be;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ack;
    logic              ld_req, ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [1:0]        ld_be;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_ack;
    logic              sd_req, sd_we;
    logic [ADDR_W-1:0] sd_addr;
    logic [DATA_W-1:0] sd_wdata;
    logic [1:0]        sd_be;
    logic [DATA_W-1:0] sd_rdata;
    logic              sd_ack;
    logic [1:0]        owner;
    logic              busy;
    logic              err_clr;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_req_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_be    (core_be),
        .core_rdata (core_rdata),
        .core_ack   (core_ack),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_be      (ld_be),
        .ld_rdata   (ld_rdata),
        .ld_ack     (ld_ack),
        .sd_req     (sd_req),
        .sd_we      (sd_we),
        .sd_addr    (sd_addr),
        .sd_wdata   (sd_wdata),
        .sd_be      (sd_be),
        .sd_rdata   (sd_rdata),
        .sd_ack     (sd_ack),
        .owner      (owner),
        .busy       (busy),
        .err_clr    (err_clr),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first ISSUE cycle: answer with sd_ack in the lat-th
    // ISSUE cycle; returns in the cycle where the ack is visible.
    task automatic serve(input int lat, input logic [DATA_W-1:0] data);
        repeat (lat - 1) step();
        sd_ack   = 1'b1;
        sd_rdata = data;
        step();
        sd_ack   = 1'b0;
        sd_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sd_req"},  32'(sd_req),      32'h0);
        check({tag, "_sd_we"},   32'(sd_we),       32'h0);
        check({tag, "_sd_addr"}, 32'(sd_addr),     32'h0);
        check({tag, "_sd_wd"},   32'(sd_wdata),    32'h0);
        check({tag, "_sd_be"},   32'(sd_be),       32'h0);
        check({tag, "_owner"},   32'(owner),       32'h0);
        check({tag, "_busy"},    32'(busy),        32'h0);
        check({tag, "_c_ack"},   32'(core_ack),    32'h0);
        check({tag, "_l_ack"},   32'(ld_ack),      32'h0);
        check({tag, "_c_rd"},    32'(core_rdata),  32'h0);
        check({tag, "_l_rd"},    32'(ld_rdata),    32'h0);
        check({tag, "_terr"},    32'(timeout_err), 32'h0);
    endtask

    logic [1:0] first_own, second_own;
    int         n;

    initial begin
        reset_n = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_be = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_be = '0;
        sd_rdata = '0; sd_ack = 0; err_clr = 0;

        // ---- reset state ----
        step(); step();
        check_all_zero("rst");
        reset_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'h0);

        // ---- single core read ----
        core_req = 1; core_we = 0; core_addr = 24'h001234; core_be = 2'b11;
        step();
        check("rd_sd_req", 32'(sd_req),  32'h1);
        check("rd_addr",   32'(sd_addr), 32'h001234);
        check("rd_we",     32'(sd_we),   32'h0);
        check("rd_owner",  32'(owner),   32'h1);
        check("rd_busy",   32'(busy),    32'h1);
        check("rd_noack",  32'(core_ack), 32'h0);
        serve(5, 16'hBEEF);
        check("rd_ack",    32'(core_ack),   32'h1);
        check("rd_data",   32'(core_rdata), 32'hBEEF);
        check("rd_ld_ack", 32'(ld_ack),     32'h0);
        check("rd_sd_dn",  32'(sd_req),     32'h0);
        check("rd_rel_own",32'(owner),      32'h0);
        $display("txn core read  addr=%06h data=%04h", 24'h001234, core_rdata);
        core_req = 0;
        step();
        check("rd_ack_pulse", 32'(core_ack),   32'h0);
        check("rd_data_hold", 32'(core_rdata), 32'hBEEF);
        check("rd_idle",      32'(busy),       32'h0);

        // ---- simultaneous requests ----
`ifdef ARB_RR_EN
        first_own = 2'b10;
`else
        first_own = 2'b01;
`endif
        second_own = first_own ^ 2'b11;
        core_req = 1; core_we = 1; core_addr = 24'h000100; core_wdata = 16'hC0DE; core_be = 2'b01;
        ld_req   = 1; ld_we   = 0; ld_addr   = 24'h00ABCD; ld_wdata   = 16'h0000; ld_be   = 2'b11;
        step();
        check("sim_own1",  32'(owner), 32'(first_own));
        check("sim_addr1", 32'(sd_addr), (first_own == 2'b01) ? 32'h000100 : 32'h00ABCD);
        serve(2, 16'h1111);
        if (first_own == 2'b01) begin
            check("sim_ack1",  32'(core_ack),   32'h1);
            check("sim_nack1", 32'(ld_ack),     32'h0);
            check("sim_rd1",   32'(core_rdata), 32'h1111);
            core_req = 0;
        end else begin
            check("sim_ack1",  32'(ld_ack),     32'h1);
            check("sim_nack1", 32'(core_ack),   32'h0);
            check("sim_rd1",   32'(ld_rdata),   32'h1111);
            ld_req = 0;
        end
        $display("txn first grant owner=%0b data=1111", first_own);
        check("sim_gap_rel", 32'(owner), 32'h0);
        step();
        check("sim_gap_idle", 32'(owner), 32'h0);
        step();
        check("sim_own2",  32'(owner), 32'(second_own));
        check("sim_addr2", 32'(sd_addr), (second_own == 2'b01) ? 32'h000100 : 32'h00ABCD);
        serve(3, 16'h2222);
        if (second_own == 2'b10) begin
            check("sim_ack2",   32'(ld_ack),     32'h1);
            check("sim_nack2",  32'(core_ack),   32'h0);
            check("sim_rd2",    32'(ld_rdata),   32'h2222);
            check("sim_keep1",  32'(core_rdata), 32'h1111);
            ld_req = 0;
        end else begin
            check("sim_ack2",   32'(core_ack),   32'h1);
            check("sim_nack2",  32'(ld_ack),     32'h0);
            check("sim_rd2",    32'(core_rdata), 32'h2222);
            check("sim_keep1",  32'(ld_rdata),   32'h1111);
            core_req = 0;
        end
        $display("txn second grant owner=%0b data=2222", second_own);
        step();

        // ---- held request: one ack per transaction, RELEASE gap ----
        core_req = 1; core_we = 0; core_addr = 24'h000200;
        step();
        check("hold_req1", 32'(sd_req), 32'h1);
        serve(1, 16'h3333);
        check("hold_ack1", 32'(core_ack), 32'h1);
        check("hold_dn1",  32'(sd_req),   32'h0);
        $display("txn core held #1 data=%04h", core_rdata);
        step();
        check("hold_gap_ack", 32'(core_ack), 32'h0);
        check("hold_gap_req", 32'(sd_req),   32'h0);
        step();
        check("hold_req2",  32'(sd_req),   32'h1);
        check("hold_nack2", 32'(core_ack), 32'h0);
        serve(1, 16'h4444);
        check("hold_ack2", 32'(core_ack),   32'h1);
        check("hold_rd2",  32'(core_rdata), 32'h4444);
        $display("txn core held #2 data=%04h", core_rdata);
        core_req = 0;
        step();
        step();
        check("hold_stop_req", 32'(sd_req), 32'h0);
        check("hold_stop_bsy", 32'(busy),   32'h0);

        // ---- watchdog: loader write never acknowledged ----
        ld_req = 1; ld_we = 1; ld_addr = 24'h00F00D; ld_wdata = 16'h5A5A; ld_be = 2'b10;
        step();
        check("wd_owner", 32'(owner),    32'h2);
        check("wd_we",    32'(sd_we),    32'h1);
        check("wd_wdata", 32'(sd_wdata), 32'h5A5A);
        check("wd_be",    32'(sd_be),    32'h2);
        ld_req = 0;  // dropped early: the transaction must still complete
        n = 1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (ld_ack) break;
            n++;
        end
        check("wd_cycles", 32'(n),           32'(TIMEOUT));
        check("wd_ack",    32'(ld_ack),      32'h1);
        check("wd_rdata",  32'(ld_rdata),    32'hFFFF);
        check("wd_err",    32'(timeout_err), 32'h1);
        check("wd_sd_dn",  32'(sd_req),      32'h0);
        check("wd_c_ack",  32'(core_ack),    32'h0);
        $display("txn loader write timeout after %0d cycles", n);
        step();
        check("wd_err_sticky", 32'(timeout_err), 32'h1);
        err_clr = 1;
        step();
        err_clr = 0;
        check("wd_err_clr", 32'(timeout_err), 32'h0);

        // ---- boundary: sd_ack in the same cycle as the timeout ----
        core_req = 1; core_we = 0; core_addr = 24'h0A0B0C;
        step();
        check("bnd_req", 32'(sd_req), 32'h1);
        serve(TIMEOUT, 16'hCAFE);
        check("bnd_ack",  32'(core_ack),    32'h1);
        check("bnd_data", 32'(core_rdata),  32'hCAFE);
        check("bnd_err",  32'(timeout_err), 32'h0);
        $display("txn core read at timeout boundary data=%04h", core_rdata);
        core_req = 0;
        step();

        // ---- reset asserted mid-ISSUE ----
        core_req = 1; core_we = 0; core_addr = 24'h123456;
        step();
        step();
        check("mrst_pre", 32'(sd_req), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mrst");
        sd_ack = 1; sd_rdata = 16'h9999;
        step();
        step();
        check("mrst_noack", 32'(core_ack), 32'h0);
        check("mrst_noreq", 32'(sd_req),   32'h0);
        sd_ack = 0; sd_rdata = '0;
        reset_n = 1'b1;
        step();
        check("mrst_req",   32'(sd_req),  32'h1);
        check("mrst_own",   32'(owner),   32'h1);
        check("mrst_addr",  32'(sd_addr), 32'h123456);
        serve(2, 16'h7777);
        check("mrst_ack",   32'(core_ack),   32'h1);
        check("mrst_data",  32'(core_rdata), 32'h7777);
        $display("txn core read after reset data=%04h", core_rdata);
        core_req = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the single SDRAM controller request port between two requesters: the Atari core (CPU/ANTIC memory cycles) and the data_io loader (ROM, cartridge and disk image upload over SPI_SS2/SPI_SS4).
- Sits between atari800core memory decode and the SDRAM controller, in the SDRAM clock domain.
- Latches one transaction at a time, forwards it downstream, and routes the completion back to the owner.
- Includes a watchdog that guarantees no requester hangs if the controller never acknowledges.

Parameters:
- ADDR_W, 24, byte address width of every port.
- DATA_W, 16, data width of every port; byte enables are DATA_W/8 bits.
- TIMEOUT, 255, maximum number of cycles to wait for sd_ack after sd_req before aborting; must be ≥ 2.

Ports:
- clk  in  1  SDRAM-domain clock; everything is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_req  in  1  core request level; held until core_ack.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core byte address.
- core_wdata  in  DATA_W  core write data.
- core_be  in  DATA_W/8  core byte enables.
- core_rdata  out  DATA_W  read data, valid in the core_ack cycle and held afterwards.
- core_ack  out  1  one-cycle completion pulse to the core.
- ld_req, ld_we, ld_addr, ld_wdata, ld_be  in  same widths as the core_* inputs  loader request.
- ld_rdata, ld_ack  out  DATA_W, 1  loader completion.
- sd_req  out  1  downstream request level.
- sd_we  out  1  downstream write strobe.
- sd_addr  out  ADDR_W  downstream address.
- sd_wdata  out  DATA_W  downstream write data.
- sd_be  out  DATA_W/8  downstream byte enables.
- sd_rdata  in  DATA_W  controller read data, valid with sd_ack.
- sd_ack  in  1  controller completion pulse.
- owner  out  2  current grant: 00 none, 01 core, 10 loader.
- busy  out  1  high in any state other than IDLE.
- err_clr  in  1  synchronous clear for timeout_err.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: clk and reset_n are the only clock and reset; reset is asynchronous, active-low. While reset_n is low, every output is 0 (rdata buses, sd_* payload, owner, busy, timeout_err), the watchdog counter is 0 and the state is IDLE.
- Reset asserted mid-transaction: the transaction is abandoned immediately and no ack is issued.
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - If core_req=1 or ld_req=1, pick the winner by the arbitration rule.
  - Latch that requester's we, addr, wdata and be into the sd_* registers.
  - Set owner, clear the watchdog, go to ISSUE.
  - sd_req rises on the same edge, so sd_req is high 1 cycle after req is sampled.
- ISSUE:
  - sd_req and the sd_* payload are held stable.
  - The watchdog increments every cycle.
  - On sd_ack=1: capture sd_rdata into the owner's rdata (for reads and writes alike), pulse the owner's ack for exactly 1 cycle, drop sd_req, go to RELEASE.
  - On watchdog reaching TIMEOUT with no sd_ack: set timeout_err, drive the owner's rdata to all ones, pulse the owner's ack, drop sd_req, go to RELEASE.
  - If sd_ack and the timeout land in the same cycle, sd_ack wins and timeout_err is not set.
- RELEASE:
  - One cycle with owner=00 and no new grant.
  - This gives the requester time to drop req, so a held-high req is never serviced twice from one ack.
  - Then go to IDLE. A req still high in IDLE is treated as a new transaction.
- Requester dropping req before ack: the latched transaction still completes and the ack is still pulsed; requesters must ignore unexpected acks.
- Throughput: one transaction per (sd_ack latency + 3) cycles minimum.
- Arbitration (default): fixed priority, core over loader.
- The non-owner's ack and rdata never change.
- err_clr clears timeout_err on the next edge; if err_clr and a new timeout occur in the same cycle, the set wins.
- Payload inputs are sampled only in IDLE; changes in other states are ignored.

Optional Feature:
- Macro ARB_RR_EN.
- When defined: round-robin arbitration. A 1-bit last-owner register (reset 0 = core) gives the requester that was not served last priority when both request in IDLE. A lone requester is always served.
- When undefined: the fixed core priority above. The loader can be starved while the core requests continuously; this is acceptable because loading happens with the core held in reset.

Test Plan:
- Single core read: core_req=1, addr=0x001234, sd_ack 5 cycles after sd_req with sd_rdata=0xBEEF. Expect sd_req 1 cycle after core_req, sd_addr=0x001234, core_ack 1-cycle pulse, core_rdata=0xBEEF, ld_ack stays 0.
- Simultaneous requests: core_req and ld_req both rise on the same edge.
  - Default build: core served first, loader second, owner 01 then 10 with a RELEASE gap (owner=00).
  - ARB_RR_EN after a prior core transaction: loader served first.
- Held request: core_req stays 1 after ack. Expect exactly one ack per transaction and a RELEASE cycle between consecutive sd_req pulses.
- Watchdog: loader write, sd_ack never asserted, TIMEOUT=255. Expect ld_ack in the 255th ISSUE cycle, ld_rdata=0xFFFF, timeout_err=1 until err_clr is pulsed, then 0.
- Reset mid-ISSUE: reset_n low while sd_req=1. Expect all outputs 0 immediately (asynchronously), no ack. After release, a new core request is serviced normally.
- Boundary: sd_ack in the same cycle the watchdog hits TIMEOUT. Expect normal completion with data passed through and timeout_err still 0.
